// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC generator: default PC width and the
// next-PC source encoding used by the select mux.
package pc_pkg;

   localparam int unsigned PC_W = 6;

   typedef enum logic [2:0] {
      SrcRst,
      SrcHold,
      SrcRet,
      SrcJmp,
      SrcCall,
      SrcBr,
      SrcInc
   } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and an occupancy
// count. Pushing when full overwrites the oldest entry; sticky ovf/unf flags.
module ras_stack #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] push_data_i,
   output logic [Width-1:0] top_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  ptr_q, ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntMax);
   assign top_o   = mem_q[ptr_q];
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (pop_i) begin
         if (empty_o) begin
            unf_d = 1'b1;
         end else begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
         end
      end else if (push_i) begin
         // When full, ptr+1 is the oldest slot, so advancing overwrites it.
         ptr_d        = ptr_q + PtrW'(1);
         mem_d[ptr_d] = push_data_i;
         if (full_o) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generator: picks the next PC from reset/stall/return/jump/call/
// branch/increment in priority order and manages the return-address stack.
module next_pc_gen #(
   parameter int unsigned PC_W      = pc_pkg::PC_W,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_cur,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_off,
   input  logic            jmp,
   input  logic            call,
   input  logic            ret,
   input  logic [PC_W-1:0] jmp_tgt,
   output logic [PC_W-1:0] pc_next,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   import pc_pkg::*;

   pc_src_e         src;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_br;
   logic [PC_W-1:0] ras_top;
   logic            stk_empty;
   logic            stk_full;
   logic            push;
   logic            pop;

   // Modulo-2^PC_W adds; a sign-extended offset is the same bits as br_off.
   assign pc_inc = pc_cur + PC_W'(1);
   assign pc_br  = pc_cur + br_off;

   always_comb begin
      src = SrcInc;
      if (rst) begin
         src = SrcRst;
      end else if (stall) begin
         src = SrcHold;
      end else if (ret) begin
         src = SrcRet;
      end else if (jmp) begin
         src = SrcJmp;
      end else if (call) begin
         src = SrcCall;
      end else if (br_taken) begin
         src = SrcBr;
      end
   end

   always_comb begin
      pc_next = pc_inc;
      unique case (src)
         SrcRst:  pc_next = '0;
         SrcHold: pc_next = pc_cur;
         SrcRet:  pc_next = stk_empty ? pc_inc : ras_top;
         SrcJmp:  pc_next = jmp_tgt;
         SrcCall: pc_next = jmp_tgt;
         SrcBr:   pc_next = pc_br;
         SrcInc:  pc_next = pc_inc;
         default: pc_next = pc_inc;
      endcase
   end

   // Only the winning request touches the stack.
   assign push = (src == SrcCall);
   assign pop  = (src == SrcRet);

   ras_stack #(
      .Depth (RAS_DEPTH),
      .Width (PC_W)
   ) u_ras (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .top_o       (ras_top),
      .empty_o     (stk_empty),
      .full_o      (stk_full),
      .ovf_o       (ras_ovf),
      .unf_o       (ras_unf)
   );

   assign ras_empty = rst | stk_empty;
   assign ras_full  = ~rst & stk_full;

endmodule
